module_timer_lobby: RTL and testbench



---
 rtl/module_timer_lobby_pkg.sv | 14 +
 rtl/module_timer_lobby_prescaler.sv | 36 +++
 rtl/module_timer_lobby.sv | 98 +++++++++
 tb/tb_module_timer_lobby.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/module_timer_lobby_pkg.sv
// Shared light-control definitions: timer state encoding and the default
// clock/timeout constants used by both the timer and the light FSM top level.
package pkg_luces;

  typedef enum logic [1:0] {
    T_IDLE  = 2'd0,
    T_COUNT = 2'd1,
    T_DONE  = 2'd2
  } timer_state_t;

  localparam int CLK_FREQ_HZ_DEF = 100_000_000;
  localparam int TIMEOUT_S_DEF   = 10;

endpackage : pkg_luces

// File: rtl/module_timer_lobby_prescaler.sv
// Free-running modulo-DIV counter; tick_o pulses for one cycle on the wrap
// from DIV-1 back to 0. A synchronous clear overrides the enable.
module module_prescaler #(
  parameter int DIV = 4
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr_i,
  input  logic en_i,
  output logic tick_o
);

  localparam int W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [W-1:0] LAST = W'(DIV - 1);

  logic [W-1:0] cnt_q, cnt_d;
  logic         wrap;

  assign wrap   = en_i && !clr_i && (cnt_q == LAST);
  assign tick_o = wrap;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)      cnt_d = '0;
    else if (wrap)  cnt_d = '0;
    else if (en_i)  cnt_d = cnt_q + 1'b1;
  end

  // NOTE: sequential state uses non-blocking (<=) so every flop samples the
  // pre-edge values; blocking here would create order-dependent simulation.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

endmodule : module_prescaler

// File: rtl/module_timer_lobby.sv
// Lobby-light hold timer: counts TIMEOUT_S seconds of the 1 s tick while en_i
// is held, then raises fin_o until en_i is released.
module module_timer_lobby
  import pkg_luces::*;
#(
  parameter int CLK_FREQ_HZ = CLK_FREQ_HZ_DEF,
  parameter int TIMEOUT_S   = TIMEOUT_S_DEF,
  parameter int SEC_W       = $clog2(TIMEOUT_S + 1)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             en_i,
  output logic             fin_o,
  output logic             busy_o,
  output logic [SEC_W-1:0] rem_o
);

  if (TIMEOUT_S < 1) begin : g_bad_timeout
    $error("module_timer_lobby: TIMEOUT_S must be >= 1");
  end
  if (CLK_FREQ_HZ < 2) begin : g_bad_freq
    $error("module_timer_lobby: CLK_FREQ_HZ must be >= 2");
  end

  localparam logic [SEC_W-1:0] REM_LOAD = SEC_W'(TIMEOUT_S);
  localparam logic [SEC_W-1:0] REM_ONE  = SEC_W'(1);

  timer_state_t     state_q, state_d;
  logic [SEC_W-1:0] rem_q, rem_d;
  logic             tick;
  logic             counting;

  assign counting = (state_q == T_COUNT);

  // Prescaler is held at zero outside T_COUNT and on an abort, so every
  // count starts a full second from edge 0.
  module_prescaler #(
    .DIV (CLK_FREQ_HZ)
  ) u_prescaler (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .clr_i  (!counting || !en_i),
    .en_i   (counting),
    .tick_o (tick)
  );

  always_comb begin
    // NOTE: every variable gets a default before the case so no path leaves
    // it unassigned, which would otherwise infer a latch.
    state_d = state_q;
    rem_d   = rem_q;
    unique case (state_q)
      T_IDLE: begin
        rem_d = '0;
        if (en_i) begin
          state_d = T_COUNT;
          rem_d   = REM_LOAD;
        end
      end
      T_COUNT: begin
        if (!en_i) begin
          state_d = T_IDLE;
          rem_d   = '0;
        end else if (tick) begin
          if (rem_q <= REM_ONE) begin
            state_d = T_DONE;
            rem_d   = '0;
          end else begin
            rem_d = rem_q - 1'b1;
          end
        end
      end
      T_DONE: begin
        rem_d = '0;
        if (!en_i) state_d = T_IDLE;
      end
      default: begin
        state_d = T_IDLE;
        rem_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= T_IDLE;
      rem_q   <= '0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
    end
  end

  assign fin_o  = (state_q == T_DONE);
  assign busy_o = counting;
  assign rem_o  = rem_q;

endmodule : module_timer_lobby

// File: tb/tb_module_timer_lobby.sv
// Self-checking bench for module_timer_lobby with F=4, T=3: vector table with
// scoreboard queue, plus async-reset and light-FSM loop sequences.
module tb_module_timer_lobby;

  localparam int F     = 4;
  localparam int T     = 3;
  localparam int SEC_W = 2;

  typedef struct {
    logic             en;
    logic             fin;
    logic             busy;
    logic [SEC_W-1:0] rem;
  } vec_t;

  logic             clk;
  logic             rst_n;
  logic             en_i;
  logic             en_drv;
  logic             fsm_mode;
  logic             fin_o;
  logic             busy_o;
  logic [SEC_W-1:0] rem_o;

  // Minimal light FSM: p1 pulse requests the timer, fin returns it to default.
  logic       p1;
  logic       lf_st;
  logic [2:0] lf_b;

  int n_vec;
  int n_err;

  vec_t vecs[$];
  vec_t exp_q[$];

  assign en_i = fsm_mode ? lf_st : en_drv;

  module_timer_lobby #(
    .CLK_FREQ_HZ (F),
    .TIMEOUT_S   (T),
    .SEC_W       (SEC_W)
  ) dut (
    .clk_i  (clk),
    .rst_i  (rst_n),
    .en_i   (en_i),
    .fin_o  (fin_o),
    .busy_o (busy_o),
    .rem_o  (rem_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lf_st <= 1'b0;
      lf_b  <= 3'b000;
    end else if (!lf_st && p1) begin
      lf_st <= 1'b1;
      lf_b  <= 3'b101;
    end else if (lf_st && fin_o) begin
      lf_st <= 1'b0;
      lf_b  <= 3'b000;
    end
  end

  task automatic check(input string name, input int act, input int req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  function automatic void add(input logic en, input logic fin,
                              input logic busy, input int rem);
    vec_t v;
    v.en   = en;
    v.fin  = fin;
    v.busy = busy;
    v.rem  = SEC_W'(rem);
    vecs.push_back(v);
  endfunction

  // One full count from edge 0: rem = T - k/F after edge k, done after T*F.
  function automatic void add_full_count();
    for (int k = 0; k < T * F; k++) add(1'b1, 1'b0, 1'b1, T - k / F);
    add(1'b1, 1'b1, 1'b0, 0);
  endfunction

  function automatic int outs();
    return {29'd0, fin_o, busy_o, rem_o};
  endfunction

  initial begin
    vec_t v;
    vec_t e;
    int   n;

    n_vec    = 0;
    n_err    = 0;
    rst_n    = 1'b0;
    en_drv   = 1'b0;
    fsm_mode = 1'b0;
    p1       = 1'b0;

    // Full count, hold in done, release, restart, release.
    add_full_count();
    add(1'b1, 1'b1, 1'b0, 0);
    add(1'b1, 1'b1, 1'b0, 0);
    add(1'b0, 1'b0, 1'b0, 0);
    add_full_count();
    add(1'b0, 1'b0, 1'b0, 0);
    // Abort at edge 6 with rem=2; fin never asserts.
    for (int k = 0; k < 6; k++) add(1'b1, 1'b0, 1'b1, T - k / F);
    add(1'b0, 1'b0, 1'b0, 0);
    add(1'b0, 1'b0, 1'b0, 0);
    // Abort exactly on the wrap at edge 8 wins over the decrement.
    for (int k = 0; k < 8; k++) add(1'b1, 1'b0, 1'b1, T - k / F);
    add(1'b0, 1'b0, 1'b0, 0);
    add(1'b1, 1'b0, 1'b1, T);
    add(1'b0, 1'b0, 1'b0, 0);

    repeat (2) @(posedge clk);
    #1 check("reset_state", outs(), 0);
    @(negedge clk) rst_n = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      v      = vecs[i];
      en_drv = v.en;
      exp_q.push_back(v);
      @(posedge clk);
      #1;
      e = exp_q.pop_front();
      check($sformatf("vec%0d", i), outs(), {29'd0, e.fin, e.busy, e.rem});
    end

    // Asynchronous reset mid-count with rem=2, no clock edge involved.
    @(negedge clk) en_drv = 1'b1;
    repeat (5) @(posedge clk);
    #2 check("pre_reset_rem", int'(rem_o), 2);
    rst_n = 1'b0;
    #1 check("async_reset", outs(), 0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #1 check("fresh_after_reset", outs(), {29'd0, 1'b0, 1'b1, 2'(T)});
    @(negedge clk) en_drv = 1'b0;
    @(posedge clk);
    #1 check("idle_after_reset_seq", outs(), 0);

    // Light FSM loop: p1 pulse, timer runs, FSM returns to default.
    @(negedge clk);
    fsm_mode = 1'b1;
    p1       = 1'b1;
    @(negedge clk) p1 = 1'b0;
    n = 0;
    while (!busy_o && n < 10) begin
      @(posedge clk);
      #1 n++;
    end
    check("fsm_en_started", int'(busy_o), 1);
    check("fsm_en_high", int'(lf_st), 1);
    n = 0;
    while (!fin_o && n < 100) begin
      @(posedge clk);
      #1 n++;
    end
    check("fsm_fin_latency", n, T * F);
    repeat (2) @(posedge clk);
    #1;
    check("fsm_default", int'(lf_st), 0);
    check("fsm_b", int'(lf_b), 0);
    check("fsm_timer_idle", outs(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule : tb_module_timer_lobby
